// File: rtl/bus_pkg.sv
// Shared definitions for the two-master bus arbiter: FSM state encoding,
// master index constants and a small index-to-one-hot helper.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Master indices: the CPU is master 0, the DMA engine is master 1.
  localparam logic M_CPU = 1'b0;
  localparam logic M_DMA = 1'b1;

  // Expand a master index into its one-hot per-master strobe vector.
  function automatic logic [1:0] idx_onehot(input logic idx);
    idx_onehot = idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick2.sv
// Two-way round-robin picker: with both requests high the master that was
// not served last wins; a lone requester always wins.
module rr_pick2
  import bus_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner,
  output logic       valid
);

  // Pure combinational selection; the caller registers the result.
  always_comb begin
    valid  = |req;
    winner = M_CPU;
    if (req == 2'b11) begin
      winner = ~last;
    end else if (req[1]) begin
      winner = M_DMA;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master (CPU / DMA) single-slave bus arbiter with IDLE/ACCESS/DONE FSM.
// The winner's request fields are latched at grant so the slave bus stays
// stable for the whole access. mDone/mErr are registered one-cycle pulses
// issued on the edge that leaves DONE.
// Optional feature: define BUS_ARBITER_TIMEOUT_EN to abort an access after
// TIMEOUT_CYC ACCESS cycles without busReady (completes with mErr and zero
// read data). Without the macro the arbiter waits forever and mErr is 0.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mReq,
  input  logic [1:0]       mWe,
  input  logic [1:0][31:0] mAddr,
  input  logic [1:0][31:0] mWData,
  input  logic [1:0][1:0]  mLS,
  input  logic [1:0]       mSign,
  output logic [1:0]       mGnt,
  output logic [1:0][31:0] mRData,
  output logic [1:0]       mDone,
  output logic [1:0]       mErr,
  output logic             busWe,
  output logic [31:0]      busAddr,
  output logic [31:0]      busWData,
  output logic [1:0]       LSControl,
  output logic             SignControl,
  input  logic [31:0]      busRData,
  input  logic             busReady
);

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  localparam int             CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t            state_q, state_d;
  logic              win_q, win_d;
  logic              last_q, last_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        done_q, done_d;
  logic [1:0]        err_q, err_d;
  logic [1:0][31:0]  rdata_q, rdata_d;
  logic              abort_q, abort_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              lat_we_q, lat_we_d;
  logic [31:0]       lat_addr_q, lat_addr_d;
  logic [31:0]       lat_wdata_q, lat_wdata_d;
  logic [1:0]        lat_ls_q, lat_ls_d;
  logic              lat_sign_q, lat_sign_d;

  logic              pick_winner;
  logic              pick_valid;
  logic              timeout_hit;

  rr_pick2 u_pick (
    .req    (mReq),
    .last   (last_q),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  // Timeout fires on the last allowed ACCESS cycle when the slave is still not ready.
  assign timeout_hit = TMO_EN && (state_q == ST_ACCESS) && !busReady && (cnt_q == CNT_LAST);

  // State register: reset aborts any access in flight and returns to IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (pick_valid) state_d = ST_ACCESS;
      ST_ACCESS: if (busReady || timeout_hit) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Per-state updates of grant, completion pulses, read data and latched request.
  always_comb begin
    win_d       = win_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    done_d      = '0;
    err_d       = '0;
    rdata_d     = rdata_q;
    abort_d     = abort_q;
    cnt_d       = '0;
    lat_we_d    = lat_we_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    lat_ls_d    = lat_ls_q;
    lat_sign_d  = lat_sign_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          win_d       = pick_winner;
          gnt_d       = idx_onehot(pick_winner);
          abort_d     = 1'b0;
          lat_we_d    = mWe[pick_winner];
          lat_addr_d  = mAddr[pick_winner];
          lat_wdata_d = mWData[pick_winner];
          lat_ls_d    = mLS[pick_winner];
          lat_sign_d  = mSign[pick_winner];
        end
      end
      ST_ACCESS: begin
        if (TMO_EN) cnt_d = cnt_q + 1'b1;
        if (busReady) begin
          rdata_d[win_q] = busRData;
        end else if (timeout_hit) begin
          rdata_d[win_q] = '0;
          abort_d        = 1'b1;
        end
      end
      ST_DONE: begin
        gnt_d  = '0;
        last_d = win_q;
        done_d = idx_onehot(win_q);
        err_d  = abort_q ? idx_onehot(win_q) : 2'b00;
      end
      default: ;
    endcase
  end

  // Control and master-facing output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_q   <= M_CPU;
      last_q  <= M_DMA;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      rdata_q <= '0;
      abort_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      win_q   <= win_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      abort_q <= abort_d;
      cnt_q   <= cnt_d;
    end
  end

  // Latched request fields: only observed while in ACCESS, so no reset needed.
  always_ff @(posedge clk) begin
    lat_we_q    <= lat_we_d;
    lat_addr_q  <= lat_addr_d;
    lat_wdata_q <= lat_wdata_d;
    lat_ls_q    <= lat_ls_d;
    lat_sign_q  <= lat_sign_d;
  end

  // Slave bus carries the latched request during ACCESS and is zero otherwise.
  always_comb begin
    busWe       = 1'b0;
    busAddr     = '0;
    busWData    = '0;
    LSControl   = '0;
    SignControl = 1'b0;
    if (state_q == ST_ACCESS) begin
      busWe       = lat_we_q;
      busAddr     = lat_addr_q;
      busWData    = lat_wdata_q;
      LSControl   = lat_ls_q;
      SignControl = lat_sign_q;
    end
  end

  assign mGnt   = gnt_q;
  assign mDone  = done_q;
  assign mRData = rdata_q;
  assign mErr   = TMO_EN ? err_q : 2'b00;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed transactions push expected
// completions; a negedge monitor pops one entry per mDone/mErr pulse.
`timescale 1ns/1ps
module tb_bus_arbiter;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       mReq, mWe, mSign;
  logic [1:0][31:0] mAddr, mWData;
  logic [1:0][1:0]  mLS;
  logic [1:0]       mGnt, mDone, mErr;
  logic [1:0][31:0] mRData;
  logic             busWe;
  logic [31:0]      busAddr, busWData;
  logic [1:0]       LSControl;
  logic             SignControl;
  logic [31:0]      busRData;
  logic             busReady;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic        idx;
    logic [31:0] rdata;
    logic        err;
    int          at;
  } exp_t;

  exp_t sbq[$];

  bus_arbiter #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset(reset),
    .mReq(mReq), .mWe(mWe), .mAddr(mAddr), .mWData(mWData), .mLS(mLS), .mSign(mSign),
    .mGnt(mGnt), .mRData(mRData), .mDone(mDone), .mErr(mErr),
    .busWe(busWe), .busAddr(busAddr), .busWData(busWData),
    .LSControl(LSControl), .SignControl(SignControl),
    .busRData(busRData), .busReady(busReady)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic issue(input logic idx, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] ls, input logic sign);
    mWe[idx]    = we;
    mAddr[idx]  = addr;
    mWData[idx] = wdata;
    mLS[idx]    = ls;
    mSign[idx]  = sign;
    mReq[idx]   = 1'b1;
  endtask

  task automatic expect_done(input logic idx, input logic [31:0] rd, input logic err, input int at);
    exp_t e;
    e.idx = idx; e.rdata = rd; e.err = err; e.at = at;
    sbq.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  // Monitor: every completion pulse must match the oldest expected entry.
  always @(negedge clk) begin : monitor
    exp_t       e;
    logic [1:0] oh;
    if (reset === 1'b1 && (mDone !== 2'b00 || mErr !== 2'b00)) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", {28'd0, mErr, mDone}, 32'd0);
      end else begin
        e  = sbq.pop_front();
        oh = e.idx ? 2'b10 : 2'b01;
        chk("done_bits", {30'd0, mDone}, {30'd0, oh});
        chk("err_bits", {30'd0, mErr}, e.err ? {30'd0, oh} : 32'd0);
        chk("done_rdata", mRData[e.idx], e.rdata);
        chk("done_cycle", cyc, e.at);
        chk("gnt_at_done", {30'd0, mGnt}, 32'd0);
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int c;
    int we_cnt;
    reset = 1'b0; mReq = '0; mWe = '0; mSign = '0; mAddr = '0; mWData = '0; mLS = '0;
    busRData = '0; busReady = 1'b0;
    repeat (2) tick();
    #1;
    chk("rst_gnt", {30'd0, mGnt}, 32'd0);
    chk("rst_done", {30'd0, mDone}, 32'd0);
    chk("rst_err", {30'd0, mErr}, 32'd0);
    chk("rst_rdata0", mRData[0], 32'd0);
    chk("rst_rdata1", mRData[1], 32'd0);
    chk("rst_bus", {busWe, LSControl, SignControl, busAddr[27:0]}, 32'd0);
    chk("rst_wdata", busWData, 32'd0);
    reset = 1'b1;
    tick();

    // Single CPU write, slave always ready.
    c = cyc;
    busReady = 1'b1;
    busRData = 32'hAAAA5555;
    issue(1'b0, 1'b1, 32'h0000_1000, 32'hDEADBEEF, 2'b10, 1'b1);
    expect_done(1'b0, 32'hAAAA5555, 1'b0, c + 3);
    we_cnt = 0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      #1;
      if (i == 1) begin
        chk("wr_gnt", {30'd0, mGnt}, 32'd1);
        mReq[0] = 1'b0; mAddr[0] = 32'hFFFF_0000; mWData[0] = '0; mWe[0] = 1'b0;
        #1;
        chk("wr_addr_stable", busAddr, 32'h0000_1000);
        chk("wr_wdata", busWData, 32'hDEADBEEF);
        chk("wr_ls_sign", {29'd0, LSControl, SignControl}, 32'd5);
      end
      if (busWe === 1'b1 && busAddr === 32'h0000_1000) we_cnt++;
    end
    chk("wr_we_cycles", we_cnt, 1);

    // Simultaneous requests right after reset: CPU first, DMA three edges later.
    do_reset();
    c = cyc;
    busRData = 32'h0BADF00D;
    issue(1'b0, 1'b0, 32'h0000_0100, 32'd0, 2'b00, 1'b0);
    issue(1'b1, 1'b0, 32'h0000_0200, 32'd0, 2'b01, 1'b0);
    expect_done(1'b0, 32'h0BADF00D, 1'b0, c + 3);
    expect_done(1'b1, 32'h0BADF00D, 1'b0, c + 6);
    tick();
    #1;
    chk("tie_gnt_first", {30'd0, mGnt}, 32'd1);
    mReq[0] = 1'b0;
    repeat (3) tick();
    #1;
    chk("tie_gnt_second", {30'd0, mGnt}, 32'd2);
    chk("tie_addr_second", busAddr, 32'h0000_0200);
    mReq[1] = 1'b0;
    repeat (4) tick();

    // Both masters hold requests for four transactions: grants alternate.
    c = cyc;
    busRData = 32'h29292929;
    issue(1'b0, 1'b0, 32'h0000_0300, 32'd0, 2'b00, 1'b0);
    issue(1'b1, 1'b0, 32'h0000_0400, 32'd0, 2'b00, 1'b0);
    expect_done(1'b0, 32'h29292929, 1'b0, c + 3);
    expect_done(1'b1, 32'h29292929, 1'b0, c + 6);
    expect_done(1'b0, 32'h29292929, 1'b0, c + 9);
    expect_done(1'b1, 32'h29292929, 1'b0, c + 12);
    for (int k = 0; k < 4; k++) begin
      repeat ((k == 0) ? 1 : 3) tick();
      #1;
      chk("rr_gnt", {30'd0, mGnt}, (k % 2 == 1) ? 32'd2 : 32'd1);
    end
    mReq = '0;
    repeat (4) tick();

    // DMA read with five not-ready cycles before the slave answers.
    c = cyc;
    busReady = 1'b0;
    busRData = 32'h12345678;
    issue(1'b1, 1'b0, 32'h0000_3000, 32'd0, 2'b00, 1'b0);
    expect_done(1'b1, 32'h12345678, 1'b0, c + 8);
    tick();
    #1;
    chk("slow_gnt", {30'd0, mGnt}, 32'd2);
    mReq[1] = 1'b0;
    repeat (5) tick();
    #1;
    chk("slow_rdata_hold", mRData[1], 32'h29292929);
    busReady = 1'b1;
    repeat (4) tick();
    chk("rdata0_hold", mRData[0], 32'h29292929);

    // Reset asserted in the second ACCESS cycle aborts without completion.
    c = cyc;
    busReady = 1'b0;
    issue(1'b0, 1'b1, 32'h0000_4000, 32'h0000_0055, 2'b01, 1'b0);
    tick();
    mReq[0] = 1'b0;
    tick();
    #1;
    chk("pre_abort_we", {31'd0, busWe}, 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_bus", {busWe, LSControl, SignControl, busAddr[27:0]}, 32'd0);
    chk("abort_wdata", busWData, 32'd0);
    chk("abort_gnt", {30'd0, mGnt}, 32'd0);
    chk("abort_rdata1", mRData[1], 32'd0);
    tick();
    reset = 1'b1;
    repeat (4) tick();
    c = cyc;
    busReady = 1'b1;
    busRData = 32'hC0FFEE00;
    issue(1'b0, 1'b0, 32'h0000_5000, 32'd0, 2'b00, 1'b0);
    expect_done(1'b0, 32'hC0FFEE00, 1'b0, c + 3);
    tick();
    mReq[0] = 1'b0;
    repeat (4) tick();

`ifdef BUS_ARBITER_TIMEOUT_EN
    // Slave never answers: forced abort after 16 ACCESS cycles.
    c = cyc;
    busReady = 1'b0;
    busRData = 32'hBAD0BAD0;
    issue(1'b0, 1'b0, 32'h0000_6000, 32'd0, 2'b00, 1'b0);
    expect_done(1'b0, 32'd0, 1'b1, c + 18);
    tick();
    mReq[0] = 1'b0;
    repeat (15) tick();
    #1;
    chk("tmo_still_access", {31'd0, busWe === 1'b0 && busAddr === 32'h0000_6000}, 32'd1);
    repeat (4) tick();
    c = cyc;
    busReady = 1'b1;
    busRData = 32'h600D600D;
    issue(1'b0, 1'b0, 32'h0000_7000, 32'd0, 2'b00, 1'b0);
    expect_done(1'b0, 32'h600D600D, 1'b0, c + 3);
    tick();
    mReq[0] = 1'b0;
    repeat (4) tick();
`endif

    repeat (3) tick();
    chk("sb_empty", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 16: number of ACCESS cycles without busReady before a forced abort.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-004 SHALL have, for each master n in {0 = CPU, 1 = DMA}, these inputs: mReq[n] (1), mWe[n] (1), mAddr[n] (32), mWData[n] (32), mLS[n] (2), mSign[n] (1).
REQ-005 SHALL have, for each master n, these outputs: mGnt[n] (1, access granted), mRData[n] (32, read data), mDone[n] (1, completion pulse), mErr[n] (1, completion with timeout).
REQ-006 SHALL have slave-side outputs busWe (1), busAddr (32), busWData (32), LSControl (2) and SignControl (1).
REQ-007 SHALL have slave-side inputs busRData (32) and busReady (1, slave completes the access this cycle).

Function
REQ-008 SHALL implement a registered FSM with states IDLE, ACCESS and DONE.
REQ-009 In IDLE with any mReq high, SHALL choose the winner, latch the winner's we/addr/wdata/ls/sign, set mGnt[winner]=1 and go to ACCESS on the next edge.
REQ-010 SHALL arbitrate round-robin: when both requests are high, the master not served last wins; a single requester always wins.
REQ-011 In ACCESS, SHALL drive the slave bus from the latched fields only; changes on master inputs SHALL NOT affect the bus.
REQ-012 In ACCESS with busReady=1, SHALL capture busRData into mRData[winner] and go to DONE.
REQ-013 In DONE, SHALL assert mDone[winner] for exactly one cycle, clear mGnt, record the winner as last-served and return to IDLE.
REQ-014 SHALL give minimum latency of 3 edges from mReq rising to mDone high when busReady is held at 1.
REQ-015 Outside ACCESS, SHALL hold busWe=0, busAddr=0, busWData=0, LSControl=0 and SignControl=0.
REQ-016 If the winner drops mReq during ACCESS, SHALL still complete the access normally.
REQ-017 SHALL keep a requester that loses arbitration pending; it is served in the next IDLE if its mReq is still high.
REQ-018 SHALL hold mRData[n] until master n's next completion.
REQ-019 SHALL assert mGnt[n] and mDone[n] for at most one master at any time.

Reset
REQ-020 When reset=0, SHALL immediately force state IDLE, clear all outputs and the timeout counter, and set last-served = master 1 so master 0 wins the first tie.
REQ-021 If reset is asserted during ACCESS, SHALL abort the access with no mDone.

Configuration
REQ-022 With macro BUS_ARBITER_TIMEOUT_EN defined, SHALL count ACCESS cycles.
REQ-023 With BUS_ARBITER_TIMEOUT_EN defined, when the count reaches TIMEOUT_CYC without busReady, SHALL go to DONE with mRData[winner]=0 and mErr[winner]=1 for the same single cycle as mDone.
REQ-024 With BUS_ARBITER_TIMEOUT_EN undefined, SHALL wait indefinitely for busReady and tie mErr to 0.

Structure
REQ-025 SHALL place the state enum (IDLE, ACCESS, DONE) and the master-index constants in shared package bus_pkg.
REQ-026 SHALL implement round-robin winner selection as sub-module rr_pick2 (inputs req[1:0] and last; output winner, valid).

Verification
REQ-027 Master 0 only, addr 0x0000_1000, write wdata 0xDEADBEEF, busReady=1: busWe=1 and busAddr=0x1000 for exactly 1 cycle; mDone[0] 3 edges after req.
REQ-028 Both masters request at the same edge after reset: master 0 served first, then master 1, with the two mDone pulses 3 edges apart.
REQ-029 Both masters hold mReq high for 4 transactions: grants alternate 0,1,0,1.
REQ-030 Master 1 read with busReady delayed 5 cycles and busRData=0x12345678: mRData[1]=0x12345678, mDone[1] 8 edges after req.
REQ-031 With BUS_ARBITER_TIMEOUT_EN defined, TIMEOUT_CYC=16 and busReady held 0: mErr[0]=mDone[0]=1 and mRData[0]=0 after 16 ACCESS cycles; the next request is served normally.
REQ-032 Reset pulse in the second ACCESS cycle: no mDone; all bus outputs 0 within the reset cycle; a new request afterward completes normally.
